// File: rtl/vliw_pkg.sv
// Shared VLIW instruction RAM constants, loader state encoding and the
// instruction field layout used by both the program loader and the sequencer.
package vliw_pkg;

    localparam int VLIW_WIDTH      = 72;
    localparam int VLIW_ADDR_WIDTH = 9;
    localparam int VLIW_DEPTH      = 512;
    localparam int BEATS_PER_WORD  = 5;
    localparam int HOST_BEAT_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_ASSEMBLE,
        ST_WRITE,
        ST_FINISH
    } loaderState_e;

    // Instruction field layout, LSB first; the five fields tile all 72 bits.
    localparam int COEF_LSB          = 0;
    localparam int COEF_WIDTH        = 32;
    localparam int STATE_READ_LSB    = 32;
    localparam int STATE_READ_WIDTH  = 9;
    localparam int EXT_BITSTREAM_LSB = 41;
    localparam int EXT_BITSTREAM_WIDTH = 16;
    localparam int SIGMA_DELTA_LSB   = 57;
    localparam int SIGMA_DELTA_WIDTH = 8;
    localparam int LOGGING_LSB       = 65;
    localparam int LOGGING_WIDTH     = 7;

    function automatic int beatLsb(input int beat);
        return beat * HOST_BEAT_WIDTH;
    endfunction

endpackage

// File: rtl/vliw_word_assembler.sv
// Collects 16-bit host beats into one 72-bit instruction word; the final beat
// supplies only its low byte and flags a pad error if its upper byte is non-zero.
module vliw_word_assembler
    import vliw_pkg::*;
#(
    parameter int NUM_BEATS = BEATS_PER_WORD
) (
    input  logic                       clock_200,
    input  logic                       reset,
    input  logic                       clear_i,
    input  logic                       beat_valid_i,
    input  logic [HOST_BEAT_WIDTH-1:0] beat_data_i,
    output logic [VLIW_WIDTH-1:0]      word_o,
    output logic                       word_complete_o,
    output logic                       pad_error_o
);

    localparam int LOW_W = (NUM_BEATS - 1) * HOST_BEAT_WIDTH;
    localparam int TOP_W = VLIW_WIDTH - LOW_W;
    localparam int CNT_W = $clog2(NUM_BEATS);

    logic [CNT_W-1:0] beatCount_q;
    logic [LOW_W-1:0] lowWord_q;
    logic             lastBeat;

    assign lastBeat = (beatCount_q == CNT_W'(NUM_BEATS - 1));

    always_ff @(posedge clock_200) begin
        if (reset || clear_i) begin
            beatCount_q <= '0;
            lowWord_q   <= '0;
        end else if (beat_valid_i) begin
            if (lastBeat) begin
                beatCount_q <= '0;
            end else begin
                beatCount_q <= beatCount_q + 1'b1;
                for (int k = 0; k < NUM_BEATS - 1; k++) begin
                    if (beatCount_q == CNT_W'(k)) begin
                        lowWord_q[beatLsb(k) +: HOST_BEAT_WIDTH] <= beat_data_i;
                    end
                end
            end
        end
    end

    // The last beat is not stored here; the loader registers the full word directly.
    assign word_o          = {beat_data_i[TOP_W-1:0], lowWord_q};
    assign word_complete_o = beat_valid_i && lastBeat;
    assign pad_error_o     = word_complete_o && (|beat_data_i[HOST_BEAT_WIDTH-1:TOP_W]);

endmodule

// File: rtl/vliw_program_loader.sv
// Halts the slice sequencer, drains its pipeline and writes a host program into
// the VLIW instruction RAM. Optional checksum: define VLIW_LOADER_CHECKSUM_EN.
module vliw_program_loader
    import vliw_pkg::*;
#(
    parameter int DRAIN_CYCLES   = 6,
    parameter int BEATS_PER_WORD = vliw_pkg::BEATS_PER_WORD
) (
    input  logic                       clock_200,
    input  logic                       reset,
    input  logic                       host_run_request,
    input  logic                       load_start,
    input  logic [VLIW_ADDR_WIDTH-1:0] load_base_address,
    input  logic [VLIW_ADDR_WIDTH:0]   load_word_count,
    input  logic [HOST_BEAT_WIDTH-1:0] host_data,
    input  logic                       host_valid,
    output logic                       host_ready,
    output logic                       write_enable,
    output logic [VLIW_ADDR_WIDTH-1:0] write_address,
    output logic [VLIW_WIDTH-1:0]      write_data,
    output logic                       vliw_start,
    output logic                       loader_busy,
    output logic                       load_done,
    output logic                       load_error,
    output logic [HOST_BEAT_WIDTH-1:0] load_checksum
);

    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
    localparam int END_W   = VLIW_ADDR_WIDTH + 2;

    loaderState_e               state_q;
    logic [DRAIN_W-1:0]         drainCount_q;
    logic [VLIW_ADDR_WIDTH-1:0] base_q;
    logic [VLIW_ADDR_WIDTH-1:0] index_q;
    logic [VLIW_ADDR_WIDTH:0]   count_q;
    logic                       hostReady_q;
    logic                       writeEnable_q;
    logic [VLIW_ADDR_WIDTH-1:0] writeAddress_q;
    logic [VLIW_WIDTH-1:0]      writeData_q;
    logic                       vliwStart_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       error_q;

    logic [END_W-1:0]           loadEnd_d;
    logic                       requestBad;
    logic                       acceptStart;
    logic                       beatAccept;
    logic                       lastWord;
    logic [VLIW_WIDTH-1:0]      assembledWord;
    logic                       wordComplete;
    logic                       padError;

    // Widened sum so an oversized count can never wrap into a legal range.
    assign loadEnd_d   = END_W'(load_base_address) + END_W'(load_word_count);
    assign requestBad  = (load_word_count == '0) || (loadEnd_d > END_W'(VLIW_DEPTH));
    assign acceptStart = (state_q == ST_IDLE) && load_start && !requestBad;
    assign beatAccept  = host_valid && hostReady_q;
    assign lastWord    = ({1'b0, index_q} == (count_q - 1'b1));

    vliw_word_assembler #(
        .NUM_BEATS(BEATS_PER_WORD)
    ) u_assembler (
        .clock_200      (clock_200),
        .reset          (reset),
        .clear_i        (acceptStart),
        .beat_valid_i   (beatAccept),
        .beat_data_i    (host_data),
        .word_o         (assembledWord),
        .word_complete_o(wordComplete),
        .pad_error_o    (padError)
    );

    always_ff @(posedge clock_200) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            drainCount_q   <= '0;
            base_q         <= '0;
            index_q        <= '0;
            count_q        <= '0;
            hostReady_q    <= 1'b0;
            writeEnable_q  <= 1'b0;
            writeAddress_q <= '0;
            writeData_q    <= '0;
            vliwStart_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            writeEnable_q <= 1'b0;
            done_q        <= 1'b0;
            if (padError) begin
                error_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    vliwStart_q <= host_run_request;
                    if (load_start) begin
                        if (requestBad) begin
                            error_q <= 1'b1;
                        end else begin
                            base_q       <= load_base_address;
                            count_q      <= load_word_count;
                            index_q      <= '0;
                            error_q      <= 1'b0;
                            vliwStart_q  <= 1'b0;
                            drainCount_q <= DRAIN_W'(DRAIN_CYCLES);
                            busy_q       <= 1'b1;
                            state_q      <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    drainCount_q <= drainCount_q - 1'b1;
                    if (drainCount_q == DRAIN_W'(1)) begin
                        hostReady_q <= 1'b1;
                        state_q     <= ST_ASSEMBLE;
                    end
                end
                ST_ASSEMBLE: begin
                    if (wordComplete) begin
                        hostReady_q    <= 1'b0;
                        writeEnable_q  <= 1'b1;
                        writeAddress_q <= base_q + index_q;
                        writeData_q    <= assembledWord;
                        state_q        <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (lastWord) begin
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else begin
                        index_q     <= index_q + 1'b1;
                        hostReady_q <= 1'b1;
                        state_q     <= ST_ASSEMBLE;
                    end
                end
                ST_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef VLIW_LOADER_CHECKSUM_EN
    logic [HOST_BEAT_WIDTH-1:0] checksum_q;

    always_ff @(posedge clock_200) begin
        if (reset || acceptStart) begin
            checksum_q <= '0;
        end else if (beatAccept) begin
            checksum_q <= checksum_q + host_data;
        end
    end

    assign load_checksum = checksum_q;
`else
    assign load_checksum = '0;
`endif

    assign host_ready    = hostReady_q;
    assign write_enable  = writeEnable_q;
    assign write_address = writeAddress_q;
    assign write_data    = writeData_q;
    assign vliw_start    = vliwStart_q;
    assign loader_busy   = busy_q;
    assign load_done     = done_q;
    assign load_error    = error_q;

endmodule
